// File: rtl/decode_queue_if.sv
// Fetch-side and execute-side handshake bundle for decode_queue.
// slave = the queue itself; master = the fetch/execute environment.
interface decode_queue_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [6:0]      opcode;
   logic [4:0]      rd;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] imm;
   logic            reg_write;
   logic            mem_read;
   logic            mem_write;
   logic            branch;
   logic            jump;
   logic            muldiv;
   logic            illegal;
   logic [CW-1:0]   count;

   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_pc, opcode, rd, rs1, rs2, funct3, funct7,
             imm, reg_write, mem_read, mem_write, branch, jump, muldiv, illegal, count
   );

   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_pc, opcode, rd, rs1, rs2, funct3, funct7,
             imm, reg_write, mem_read, mem_write, branch, jump, muldiv, illegal, count
   );
endinterface

// File: rtl/decode_queue.sv
// Buffered RV32I decode stage: DEPTH-entry {pc, instr} queue with combinational decode of the head.
// Define DECODE_RV32M_EN to accept M-extension OP encodings (funct7 = 0000001) and drive muldiv.
module decode_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input logic           clk,
   input logic           rst,
   decode_queue_if.slave dq
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [6:0] {
      OPC_OP     = 7'b0110011,
      OPC_OP_IMM = 7'b0010011,
      OPC_LOAD   = 7'b0000011,
      OPC_STORE  = 7'b0100011,
      OPC_BRANCH = 7'b1100011,
      OPC_JAL    = 7'b1101111,
      OPC_JALR   = 7'b1100111,
      OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111
   } opcode_e;

   logic [XLEN-1:0] pc_q    [DEPTH];
   logic [XLEN-1:0] pc_d    [DEPTH];
   logic [31:0]     instr_q [DEPTH];
   logic [31:0]     instr_d [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   logic            full;
   logic            in_ready;
   logic            out_valid;
   logic            push;
   logic            pop;

   logic [31:0]     head_instr;
   logic [XLEN-1:0] head_pc;
   logic [XLEN-1:0] dec_imm;
   logic            dec_legal;
   logic            dec_rw, dec_mr, dec_mw, dec_br, dec_jp;
`ifdef DECODE_RV32M_EN
   logic            dec_md;
`endif

   // No bypass: a pop in the same cycle does not open a slot when full.
   assign full      = (count_q == CW'(DEPTH));
   assign in_ready  = !full && !dq.flush && !rst;
   assign out_valid = (count_q != '0);
   assign push      = dq.in_valid && in_ready;
   assign pop       = out_valid && dq.out_ready;

   always_comb begin
      pc_d     = pc_q;
      instr_d  = instr_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (rst || dq.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            pc_d[wr_ptr_q]    = dq.in_pc;
            instr_d[wr_ptr_q] = dq.in_instr;
            wr_ptr_d          = wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
      pc_q    <= pc_d;
      instr_q <= instr_d;
   end

   always_comb begin
      head_instr = instr_q[rd_ptr_q];
      head_pc    = pc_q[rd_ptr_q];
   end

   always_comb begin
      dec_imm   = '0;
      dec_legal = 1'b1;
      dec_rw    = 1'b0;
      dec_mr    = 1'b0;
      dec_mw    = 1'b0;
      dec_br    = 1'b0;
      dec_jp    = 1'b0;
`ifdef DECODE_RV32M_EN
      dec_md    = 1'b0;
`endif
      case (head_instr[6:0])
         OPC_OP: begin
            if (head_instr[31:25] == 7'b0000000 || head_instr[31:25] == 7'b0100000) begin
               dec_rw = 1'b1;
`ifdef DECODE_RV32M_EN
            end else if (head_instr[31:25] == 7'b0000001) begin
               dec_rw = 1'b1;
               dec_md = 1'b1;
`endif
            end else begin
               dec_legal = 1'b0;
            end
         end
         OPC_OP_IMM: begin
            dec_imm = XLEN'($signed(head_instr[31:20]));
            dec_rw  = 1'b1;
         end
         OPC_LOAD: begin
            dec_imm = XLEN'($signed(head_instr[31:20]));
            dec_rw  = 1'b1;
            dec_mr  = 1'b1;
         end
         OPC_STORE: begin
            dec_imm = XLEN'($signed({head_instr[31:25], head_instr[11:7]}));
            dec_mw  = 1'b1;
         end
         OPC_BRANCH: begin
            dec_imm = XLEN'($signed({head_instr[31], head_instr[7], head_instr[30:25],
                                     head_instr[11:8], 1'b0}));
            dec_br  = 1'b1;
         end
         OPC_JAL: begin
            dec_imm = XLEN'($signed({head_instr[31], head_instr[19:12], head_instr[20],
                                     head_instr[30:21], 1'b0}));
            dec_rw  = 1'b1;
            dec_jp  = 1'b1;
         end
         OPC_JALR: begin
            dec_imm = XLEN'($signed(head_instr[31:20]));
            dec_rw  = 1'b1;
            dec_jp  = 1'b1;
         end
         OPC_LUI, OPC_AUIPC: begin
            dec_imm = XLEN'($signed({head_instr[31:12], 12'b0}));
            dec_rw  = 1'b1;
         end
         default: dec_legal = 1'b0;
      endcase
   end

   // Everything is forced to zero while empty so stale storage never leaks out.
   always_comb begin
      dq.in_ready  = in_ready;
      dq.out_valid = out_valid;
      dq.count     = count_q;
      dq.out_pc    = out_valid ? head_pc : '0;
      dq.opcode    = out_valid ? head_instr[6:0]   : '0;
      dq.rd        = out_valid ? head_instr[11:7]  : '0;
      dq.rs1       = out_valid ? head_instr[19:15] : '0;
      dq.rs2       = out_valid ? head_instr[24:20] : '0;
      dq.funct3    = out_valid ? head_instr[14:12] : '0;
      dq.funct7    = out_valid ? head_instr[31:25] : '0;
      dq.imm       = out_valid ? dec_imm : '0;
      dq.illegal   = out_valid && !dec_legal;
      dq.reg_write = out_valid && dec_legal && dec_rw;
      dq.mem_read  = out_valid && dec_legal && dec_mr;
      dq.mem_write = out_valid && dec_legal && dec_mw;
      dq.branch    = out_valid && dec_legal && dec_br;
      dq.jump      = out_valid && dec_legal && dec_jp;
`ifdef DECODE_RV32M_EN
      dq.muldiv    = out_valid && dec_legal && dec_md;
`else
      dq.muldiv    = 1'b0;
`endif
   end
endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed scenarios plus randomized traffic against a queue model.
module tb_decode_queue;
   localparam int XLEN  = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [6:0]  opc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic        rw, mr, mw, br, jp, md, il;
   } dec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          tests = 0;
   int          fails = 0;
   logic [31:0] mq_pc  [$];
   logic [31:0] mq_ins [$];
   logic [31:0] next_pc = 32'h1000;

   decode_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) dq ();
   decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .dq(dq));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int sx(input int val, input int bits);
      return (val >= (1 << (bits - 1))) ? val - (1 << bits) : val;
   endfunction

   // Reference decode: immediates assembled as integers from the bit positions of each format.
   function automatic dec_t model(input logic [31:0] pc, input logic [31:0] w);
      dec_t     e;
      int       v;
      bit       ok;
      bit [4:0] ctl;
      e = '0;
      e.pc  = pc;
      e.opc = w[6:0];
      e.rd  = w[11:7];
      e.rs1 = w[19:15];
      e.rs2 = w[24:20];
      e.f3  = w[14:12];
      e.f7  = w[31:25];
      v = 0; ok = 1'b1; ctl = 5'b00000;
      case (w[6:0])
         7'h33: begin
            ctl = 5'b10000;
            if (w[31:25] == 7'h01) begin
`ifdef DECODE_RV32M_EN
               e.md = 1'b1;
`else
               ok = 1'b0;
`endif
            end else if (w[31:25] != 7'h00 && w[31:25] != 7'h20) ok = 1'b0;
         end
         7'h13: begin v = sx(int'(w[31:20]), 12); ctl = 5'b10000; end
         7'h03: begin v = sx(int'(w[31:20]), 12); ctl = 5'b11000; end
         7'h67: begin v = sx(int'(w[31:20]), 12); ctl = 5'b10001; end
         7'h23: begin v = sx(int'(w[31:25]) * 32 + int'(w[11:7]), 12); ctl = 5'b00100; end
         7'h63: begin
            v = sx(int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32
                   + int'(w[11:8]) * 2, 13);
            ctl = 5'b00010;
         end
         7'h6F: begin
            v = sx(int'(w[31]) * (1 << 20) + int'(w[19:12]) * (1 << 12)
                   + int'(w[20]) * (1 << 11) + int'(w[30:21]) * 2, 21);
            ctl = 5'b10001;
         end
         7'h37, 7'h17: begin v = int'(w[31:12]) << 12; ctl = 5'b10000; end
         default: ok = 1'b0;
      endcase
      if (!ok) begin ctl = 5'b00000; v = 0; e.md = 1'b0; end
      e.imm = v;
      {e.rw, e.mr, e.mw, e.br, e.jp} = ctl;
      e.il = !ok;
      return e;
   endfunction

   function automatic dec_t expect_head();
      if (mq_pc.size() == 0) return '0;
      return model(mq_pc[0], mq_ins[0]);
   endfunction

   function automatic dec_t observed();
      dec_t o;
      o.pc = dq.out_pc;  o.opc = dq.opcode; o.rd = dq.rd; o.rs1 = dq.rs1; o.rs2 = dq.rs2;
      o.f3 = dq.funct3;  o.f7 = dq.funct7;  o.imm = dq.imm;
      o.rw = dq.reg_write; o.mr = dq.mem_read; o.mw = dq.mem_write; o.br = dq.branch;
      o.jp = dq.jump;    o.md = dq.muldiv;  o.il = dq.illegal;
      return o;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 9) != 0) begin
         case ($urandom_range(0, 8))
            0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h03;
            3: w[6:0] = 7'h23;  4: w[6:0] = 7'h63;  5: w[6:0] = 7'h6F;
            6: w[6:0] = 7'h67;  7: w[6:0] = 7'h37;  default: w[6:0] = 7'h17;
         endcase
         if (w[6:0] == 7'h33) begin
            case ($urandom_range(0, 3))
               0: w[31:25] = 7'h00;
               1: w[31:25] = 7'h20;
               2: w[31:25] = 7'h01;
               default: ;
            endcase
         end
      end
      return w;
   endfunction

   task automatic drive(input logic r, input logic v, input logic [31:0] ins,
                        input logic [31:0] pc, input logic fl, input logic ordy);
      @(negedge clk);
      rst = r;
      dq.in_valid = v; dq.in_instr = ins; dq.in_pc = pc; dq.flush = fl; dq.out_ready = ordy;
      #1;
   endtask

   // Advance one clock and apply the same transfer rules to the model queue.
   task automatic tick();
      bit push, pop;
      push = dq.in_valid && (mq_pc.size() < DEPTH) && !dq.flush && !rst;
      pop  = (mq_pc.size() != 0) && dq.out_ready;
      @(posedge clk);
      if (rst || dq.flush) begin
         mq_pc.delete();
         mq_ins.delete();
      end else begin
         if (pop) begin
            void'(mq_pc.pop_front());
            void'(mq_ins.pop_front());
         end
         if (push) begin
            mq_pc.push_back(dq.in_pc);
            mq_ins.push_back(dq.in_instr);
         end
      end
      #1;
   endtask

   task automatic test_reset();
      drive(1, 1, 32'h00750293, 32'h100, 0, 0);
      tests++;
      if (dq.in_ready !== 1'b0) begin
         fails++; $display("FAIL reset_in_ready: got %b want 0", dq.in_ready);
      end
      tick();
      drive(1, 0, 0, 0, 0, 0);
      tick();
      tests++;
      if ({dq.count, dq.out_valid} !== {CW'(0), 1'b0}) begin
         fails++; $display("FAIL reset_state: count=%0d out_valid=%b want 0/0", dq.count, dq.out_valid);
      end
      tests++;
      if (observed() !== dec_t'('0)) begin
         fails++; $display("FAIL reset_outputs: got %h want 0", observed());
      end
      drive(0, 0, 0, 0, 0, 0);
      tests++;
      if (dq.in_ready !== 1'b1) begin
         fails++; $display("FAIL post_reset_in_ready: got %b want 1", dq.in_ready);
      end
   endtask

   task automatic test_decode();
      drive(0, 1, 32'h00750293, 32'h100, 0, 0);
      tick();
      tests++;
      if ({dq.out_valid, dq.rd, dq.rs1, dq.imm, dq.reg_write, dq.out_pc}
          !== {1'b1, 5'd5, 5'd10, 32'd7, 1'b1, 32'h100}) begin
         fails++; $display("FAIL addi: v=%b rd=%0d rs1=%0d imm=%0d rw=%b pc=%h want 1/5/10/7/1/100",
                           dq.out_valid, dq.rd, dq.rs1, dq.imm, dq.reg_write, dq.out_pc);
      end
      drive(0, 1, 32'h00452283, 32'h104, 0, 1);
      tick();
      tests++;
      if ({dq.mem_read, dq.imm, dq.out_pc} !== {1'b1, 32'd4, 32'h104}) begin
         fails++; $display("FAIL lw: mr=%b imm=%0d pc=%h want 1/4/104", dq.mem_read, dq.imm, dq.out_pc);
      end
      drive(0, 1, 32'h00552223, 32'h108, 0, 1);
      tick();
      tests++;
      if ({dq.mem_write, dq.rs2, dq.imm, dq.reg_write} !== {1'b1, 5'd5, 32'd4, 1'b0}) begin
         fails++; $display("FAIL sw: mw=%b rs2=%0d imm=%0d rw=%b want 1/5/4/0",
                           dq.mem_write, dq.rs2, dq.imm, dq.reg_write);
      end
      drive(0, 1, 32'h040002EF, 32'h10C, 0, 1);
      tick();
      tests++;
      if ({dq.jump, dq.reg_write, dq.imm, dq.rd} !== {1'b1, 1'b1, 32'd64, 5'd5}) begin
         fails++; $display("FAIL jal: jp=%b rw=%b imm=%0d rd=%0d want 1/1/64/5",
                           dq.jump, dq.reg_write, dq.imm, dq.rd);
      end
      tests++;
      if (observed() !== expect_head()) begin
         fails++; $display("FAIL jal_model: got %h want %h", observed(), expect_head());
      end
      drive(0, 0, 0, 0, 0, 1);
      tick();
      tests++;
      if ({dq.out_valid, dq.count} !== {1'b0, CW'(0)}) begin
         fails++; $display("FAIL drain_empty: v=%b count=%0d want 0/0", dq.out_valid, dq.count);
      end
   endtask

   task automatic test_full_wrap();
      for (int i = 0; i < DEPTH + 2; i++) begin
         drive(0, 1, rand_instr(), next_pc, 0, 0);
         next_pc += 4;
         tick();
      end
      drive(0, 1, rand_instr(), next_pc, 0, 1);
      tests++;
      if ({dq.count, dq.in_ready} !== {CW'(DEPTH), 1'b0}) begin
         fails++; $display("FAIL full: count=%0d in_ready=%b want %0d/0", dq.count, dq.in_ready, DEPTH);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0);
      tests++;
      if ({dq.count, dq.in_ready} !== {CW'(DEPTH - 1), 1'b1}) begin
         fails++; $display("FAIL drain_one: count=%0d in_ready=%b want %0d/1", dq.count, dq.in_ready, DEPTH - 1);
      end
      for (int i = 0; i < DEPTH + 2; i++) begin
         drive(0, 1, rand_instr(), next_pc, 0, (i % 2) == 1);
         next_pc += 4;
         tick();
      end
      for (int i = 0; i < DEPTH; i++) begin
         tests++;
         if (observed() !== expect_head()) begin
            fails++; $display("FAIL wrap_order[%0d]: got %h want %h", i, observed(), expect_head());
         end
         drive(0, 0, 0, 0, 0, 1);
         tick();
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 32'h00750293, next_pc, 0, 0);
         next_pc += 4;
         tick();
      end
      drive(0, 1, 32'h00B00093, 32'h999, 1, 1);
      tests++;
      if ({dq.count, dq.in_ready} !== {CW'(3), 1'b0}) begin
         fails++; $display("FAIL flush_pre: count=%0d in_ready=%b want 3/0", dq.count, dq.in_ready);
      end
      tick();
      tests++;
      if ({dq.count, dq.out_valid} !== {CW'(0), 1'b0}) begin
         fails++; $display("FAIL flush_post: count=%0d v=%b want 0/0", dq.count, dq.out_valid);
      end
      drive(0, 0, 0, 0, 0, 0);
      tick();
      tests++;
      if ({dq.count, dq.out_valid, dq.out_pc} !== {CW'(0), 1'b0, 32'h0}) begin
         fails++; $display("FAIL flush_drop: count=%0d v=%b pc=%h want 0/0/0", dq.count, dq.out_valid, dq.out_pc);
      end
   endtask

   task automatic test_muldiv();
      drive(0, 1, 32'h022081B3, 32'h200, 0, 0);
      tick();
      tests++;
`ifdef DECODE_RV32M_EN
      if ({dq.muldiv, dq.illegal, dq.reg_write} !== 3'b101) begin
         fails++; $display("FAIL mul: md=%b il=%b rw=%b want 1/0/1", dq.muldiv, dq.illegal, dq.reg_write);
      end
`else
      if ({dq.muldiv, dq.illegal, dq.reg_write, dq.mem_read, dq.mem_write, dq.branch, dq.jump}
          !== 7'b0100000) begin
         fails++; $display("FAIL mul: md=%b il=%b rw=%b mr=%b mw=%b br=%b jp=%b want il only",
                           dq.muldiv, dq.illegal, dq.reg_write, dq.mem_read, dq.mem_write, dq.branch, dq.jump);
      end
`endif
      tests++;
      if ({dq.rd, dq.rs1, dq.rs2} !== {5'd3, 5'd1, 5'd2}) begin
         fails++; $display("FAIL mul_fields: rd=%0d rs1=%0d rs2=%0d want 3/1/2", dq.rd, dq.rs1, dq.rs2);
      end
      drive(0, 0, 0, 0, 0, 1);
      tick();
   endtask

   task automatic test_illegal();
      drive(0, 1, 32'h00000000, 32'h300, 0, 0);
      tick();
      drive(0, 1, 32'h0000007F, 32'h304, 0, 0);
      tick();
      tests++;
      if ({dq.illegal, dq.reg_write, dq.mem_read, dq.mem_write, dq.branch, dq.jump, dq.out_pc}
          !== {6'b100000, 32'h300}) begin
         fails++; $display("FAIL illegal_zero: il=%b rw=%b mr=%b mw=%b br=%b jp=%b pc=%h",
                           dq.illegal, dq.reg_write, dq.mem_read, dq.mem_write, dq.branch, dq.jump, dq.out_pc);
      end
      drive(0, 0, 0, 0, 0, 1);
      tick();
      tests++;
      if ({dq.illegal, dq.reg_write, dq.mem_read, dq.mem_write, dq.branch, dq.jump, dq.opcode}
          !== {6'b100000, 7'h7F}) begin
         fails++; $display("FAIL illegal_7f: il=%b rw=%b mr=%b mw=%b br=%b jp=%b opc=%h",
                           dq.illegal, dq.reg_write, dq.mem_read, dq.mem_write, dq.branch, dq.jump, dq.opcode);
      end
      drive(0, 0, 0, 0, 0, 1);
      tick();
   endtask

   task automatic test_random();
      bit r, fl, v, ordy;
      for (int i = 0; i < 400; i++) begin
         r    = ($urandom_range(0, 49) == 0);
         fl   = ($urandom_range(0, 19) == 0);
         v    = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         drive(r, v, rand_instr(), next_pc, fl, ordy);
         next_pc += 4;
         tests++;
         if (dq.in_ready !== ((mq_pc.size() < DEPTH) && !fl && !r)) begin
            fails++; $display("FAIL rnd_in_ready[%0d]: got %b size=%0d fl=%b rst=%b",
                              i, dq.in_ready, mq_pc.size(), fl, r);
         end
         tick();
         tests++;
         if ({dq.count, dq.out_valid} !== {CW'(mq_pc.size()), mq_pc.size() != 0}) begin
            fails++; $display("FAIL rnd_count[%0d]: count=%0d v=%b want %0d", i, dq.count, dq.out_valid, mq_pc.size());
         end
         tests++;
         if (observed() !== expect_head()) begin
            fails++; $display("FAIL rnd_decode[%0d]: got %h want %h", i, observed(), expect_head());
         end
      end
   endtask

   initial begin
      dq.in_valid = 1'b0; dq.in_instr = '0; dq.in_pc = '0; dq.flush = 1'b0; dq.out_ready = 1'b0;
      test_reset();
      test_decode();
      test_full_wrap();
      test_flush();
      test_muldiv();
      test_illegal();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
